// File: rtl/pulse_sweep_sequencer.sv
// rtl/pulse_sweep_sequencer.sv - run-level sweep scheduler for the pulses generator
// Steps delay and second-pulse width across sweep points, changing values only on frame wraps.
module pulse_sweep_sequencer #(
  parameter int W          = 32,
  parameter int MIN_PERIOD = 3
) (
  input  logic         clk_pll,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] period,
  input  logic [W-1:0] delay_base,
  input  logic [W-1:0] delay_step,
  input  logic [W-1:0] p2w_base,
  input  logic [W-1:0] p2w_step,
  input  logic [15:0]  n_points,
  input  logic [15:0]  shots,
  output logic [W-1:0] delay_out,
  output logic [W-1:0] p2w_out,
  output logic         gen_reset,
  output logic         frame_start,
  output logic [15:0]  point_idx,
  output logic [15:0]  shot_idx,
  output logic         busy,
  output logic         done,
  output logic         sat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] PERIOD_MIN = W'(MIN_PERIOD);
  localparam logic [W-1:0] ONE        = W'(1);

  logic [1:0]   state;
  logic [W-1:0] fcnt;
  logic [W-1:0] period_l;
  logic [15:0]  n_points_l;
  logic [15:0]  shots_l;
  logic [W-1:0] delay_step_l;
  logic [W-1:0] p2w_step_l;

  logic [W:0]   delay_sum;
  logic [W:0]   p2w_sum;
  logic         wrap;
  logic         last_shot;
  logic         last_point;

  // Carry-out in the top bit drives saturation of the swept values.
  assign delay_sum  = {1'b0, delay_out} + {1'b0, delay_step_l};
  assign p2w_sum    = {1'b0, p2w_out} + {1'b0, p2w_step_l};
  assign wrap       = (fcnt == period_l);
  assign last_shot  = (shot_idx == shots_l - 16'd1);
  assign last_point = (point_idx == n_points_l - 16'd1);

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state        <= S_IDLE;
      fcnt         <= '0;
      period_l     <= '0;
      n_points_l   <= '0;
      shots_l      <= '0;
      delay_step_l <= '0;
      p2w_step_l   <= '0;
      delay_out    <= '0;
      p2w_out      <= '0;
      gen_reset    <= 1'b1;
      frame_start  <= 1'b0;
      point_idx    <= '0;
      shot_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat          <= 1'b0;
    end else if (abort) begin
      state       <= S_IDLE;
      fcnt        <= '0;
      gen_reset   <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          gen_reset   <= 1'b1;
          frame_start <= 1'b0;
          done        <= 1'b0;
          fcnt        <= '0;
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          period_l     <= (period < PERIOD_MIN) ? PERIOD_MIN : period;
          n_points_l   <= (n_points == 16'd0) ? 16'd1 : n_points;
          shots_l      <= (shots == 16'd0) ? 16'd1 : shots;
          delay_step_l <= delay_step;
          p2w_step_l   <= p2w_step;
          delay_out    <= delay_base;
          p2w_out      <= p2w_base;
          point_idx    <= '0;
          shot_idx     <= '0;
          sat          <= 1'b0;
          fcnt         <= '0;
          gen_reset    <= 1'b0;
          frame_start  <= 1'b1;
          state        <= S_RUN;
        end
        S_RUN: begin
          if (!wrap) begin
            fcnt        <= fcnt + ONE;
            frame_start <= 1'b0;
          end else begin
            fcnt <= '0;
            if (!last_shot) begin
              shot_idx    <= shot_idx + 16'd1;
              frame_start <= 1'b1;
            end else if (!last_point) begin
              shot_idx    <= '0;
              point_idx   <= point_idx + 16'd1;
              delay_out   <= delay_sum[W] ? '1 : delay_sum[W-1:0];
              p2w_out     <= p2w_sum[W] ? '1 : p2w_sum[W-1:0];
              sat         <= sat | delay_sum[W] | p2w_sum[W];
              frame_start <= 1'b1;
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              gen_reset   <= 1'b1;
              busy        <= 1'b0;
              frame_start <= 1'b0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sweep_sequencer.sv
// tb/tb_pulse_sweep_sequencer.sv - scoreboard bench for pulse_sweep_sequencer
// Stimulus queues expected frames/done cycles; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pulse_sweep_sequencer;

  logic        clk_pll = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] period = '0, delay_base = '0, delay_step = '0, p2w_base = '0, p2w_step = '0;
  logic [15:0] n_points = '0, shots = '0;
  logic [31:0] delay_out, p2w_out;
  logic        gen_reset, frame_start, busy, done, sat;
  logic [15:0] point_idx, shot_idx;

  pulse_sweep_sequencer #(.W(32), .MIN_PERIOD(3)) dut (
    .clk_pll(clk_pll), .reset(reset), .start(start), .abort(abort),
    .period(period), .delay_base(delay_base), .delay_step(delay_step),
    .p2w_base(p2w_base), .p2w_step(p2w_step), .n_points(n_points), .shots(shots),
    .delay_out(delay_out), .p2w_out(p2w_out), .gen_reset(gen_reset),
    .frame_start(frame_start), .point_idx(point_idx), .shot_idx(shot_idx),
    .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk_pll = ~clk_pll;

  int cyc = 0;
  always @(posedge clk_pll) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic [31:0] w;
    int          p;
    int          s;
    logic        sat;
  } frame_t;

  frame_t fq[$];
  int     dq[$];
  int     checks = 0;
  int     failures = 0;
  frame_t me;
  int     md;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk_pll) begin
    if (!reset) begin
      if (frame_start) begin
        if (fq.size() == 0) begin
          chk("unexpected_frame_start", 1, 0);
        end else begin
          me = fq.pop_front();
          chk("frame_cycle", cyc, me.cyc);
          chk("frame_delay", delay_out, me.d);
          chk("frame_p2w", p2w_out, me.w);
          chk("frame_point", point_idx, me.p);
          chk("frame_shot", shot_idx, me.s);
          chk("frame_sat", sat, me.sat);
          chk("frame_gen_reset", gen_reset, 0);
          chk("frame_busy", busy, 1);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          md = dq.pop_front();
          chk("done_cycle", cyc, md);
          chk("done_gen_reset", gen_reset, 1);
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  // Issues start and queues the expected frames/done whose cycle (relative to start) is below lim.
  task automatic run(input logic [31:0] per, input logic [15:0] n, input logic [15:0] s,
                     input logic [31:0] db, input logic [31:0] ds,
                     input logic [31:0] wb, input logic [31:0] ws,
                     input int lim, output int k);
    int          pp, nn, ss, f, rel;
    logic [31:0] d, w;
    logic [32:0] t;
    logic        sf;
    frame_t      fr;
    period = per; n_points = n; shots = s;
    delay_base = db; delay_step = ds; p2w_base = wb; p2w_step = ws;
    @(posedge clk_pll); #1;
    k = cyc;
    start = 1'b1;
    pp = (per < 3) ? 3 : int'(per);
    nn = (n == 0) ? 1 : int'(n);
    ss = (s == 0) ? 1 : int'(s);
    d = db; w = wb; sf = 1'b0; f = 0;
    for (int p = 0; p < nn; p++) begin
      for (int q = 0; q < ss; q++) begin
        rel = 2 + f * (pp + 1);
        if (rel < lim) begin
          fr.cyc = k + rel; fr.d = d; fr.w = w; fr.p = p; fr.s = q; fr.sat = sf;
          fq.push_back(fr);
        end
        f++;
      end
      t = {1'b0, d} + {1'b0, ds};
      if (t[32]) begin d = 32'hFFFF_FFFF; sf = 1'b1; end else d = t[31:0];
      t = {1'b0, w} + {1'b0, ws};
      if (t[32]) begin w = 32'hFFFF_FFFF; sf = 1'b1; end else w = t[31:0];
    end
    rel = 2 + f * (pp + 1);
    if (rel < lim) dq.push_back(k + rel);
    @(posedge clk_pll); #1;
    start = 1'b0;
    @(posedge clk_pll); #1;
    // scramble programming inputs once LOAD has passed
    period = 32'd1; n_points = 16'd9; shots = 16'd7;
    delay_base = 32'h55; delay_step = 32'h3; p2w_base = 32'h66; p2w_step = 32'h4;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk_pll); #1; end
  endtask

  task automatic drained(input string nm);
    chk({nm, "_frames_left"}, fq.size(), 0);
    chk({nm, "_done_left"}, dq.size(), 0);
  endtask

  int k;

  initial begin
    repeat (3) @(posedge clk_pll);
    #1;
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_delay", delay_out, 0);
    chk("rst_sat", sat, 0);
    reset = 1'b0;
    @(posedge clk_pll); #1;

    // basic sweep: 6 frames of 10 cycles, done 62 after start
    run(32'd9, 16'd3, 16'd2, 32'd100, 32'd10, 32'd20, 32'd5, 1000, k);
    wait_until(k + 70);
    drained("basic");

    // zero counts and period clamp: one 4-cycle frame, done 6 after start
    run(32'd1, 16'd0, 16'd0, 32'd7, 32'd1, 32'd8, 32'd1, 1000, k);
    wait_until(k + 12);
    drained("zero_clamp");

    // saturation
    run(32'd4, 16'd3, 16'd1, 32'hFFFF_FFF0, 32'h20, 32'd5, 32'd1, 1000, k);
    wait_until(k + 25);
    chk("sat_hold_idle", sat, 1);
    chk("sat_delay_hold", delay_out, 32'hFFFF_FFFF);
    drained("saturation");

    // basic again: sat cleared by LOAD; start mid-run is ignored
    run(32'd9, 16'd3, 16'd2, 32'd100, 32'd10, 32'd20, 32'd5, 1000, k);
    wait_until(k + 30);
    start = 1'b1;
    @(posedge clk_pll); #1;
    start = 1'b0;
    wait_until(k + 70);
    drained("start_in_run");

    // abort at point 1, shot 0, frame count 4
    run(32'd9, 16'd3, 16'd2, 32'd100, 32'd10, 32'd20, 32'd5, 27, k);
    wait_until(k + 26);
    chk("abort_pre_point", point_idx, 1);
    chk("abort_pre_shot", shot_idx, 0);
    abort = 1'b1;
    @(posedge clk_pll); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_gen_reset", gen_reset, 1);
    chk("abort_done", done, 0);
    chk("abort_point_hold", point_idx, 1);
    chk("abort_delay_hold", delay_out, 32'd110);
    wait_until(k + 80);
    drained("abort");

    run(32'd9, 16'd3, 16'd2, 32'd100, 32'd10, 32'd20, 32'd5, 1000, k);
    wait_until(k + 70);
    drained("after_abort");

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk_pll); #1;
    start = 1'b0; abort = 1'b0;
    repeat (5) begin @(posedge clk_pll); #1; end
    chk("contention_busy", busy, 0);
    chk("contention_gen_reset", gen_reset, 1);
    repeat (15) begin @(posedge clk_pll); #1; end
    drained("contention");

    // reset mid-run during point 2 of a saturating sweep
    run(32'd4, 16'd3, 16'd1, 32'hFFFF_FFF0, 32'h20, 32'd5, 32'd1, 14, k);
    wait_until(k + 13);
    chk("pre_reset_sat", sat, 1);
    reset = 1'b1;
    @(posedge clk_pll); #1;
    chk("mid_reset_delay", delay_out, 0);
    chk("mid_reset_p2w", p2w_out, 0);
    chk("mid_reset_gen_reset", gen_reset, 1);
    chk("mid_reset_frame_start", frame_start, 0);
    chk("mid_reset_point", point_idx, 0);
    chk("mid_reset_shot", shot_idx, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_sat", sat, 0);
    reset = 1'b0;
    repeat (20) begin @(posedge clk_pll); #1; end
    drained("reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
